// File: rtl/cw305_usb_master_pkg.sv
// Shared types and phase-timing constants for the CW305 USB register-bus master.
// USB_MASTER_RDREG_EN lengthens the strobe phase by one cycle for registered-dout responders.
package cw305_usb_master_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWdata,
        StSetup,
        StStrobe,
        StHold,
        StDone
    } state_e;

`ifdef USB_MASTER_RDREG_EN
    localparam int unsigned StrobeExtra = 1;
`else
    localparam int unsigned StrobeExtra = 0;
`endif

    localparam int unsigned TimerWidth = 8;

    function automatic int unsigned strobe_len(input int unsigned base);
        return base + StrobeExtra;
    endfunction

    // The timer flags its last cycle at zero, so a phase of N cycles loads N-1.
    function automatic logic [TimerWidth-1:0] phase_load(input int unsigned cycles);
        return TimerWidth'(cycles - 32'd1);
    endfunction

    function automatic logic [31:0] byte_index_mask(input int unsigned idx_bits);
        return (32'd1 << idx_bits) - 32'd1;
    endfunction

endpackage

// File: rtl/cw305_usb_phase_timer.sv
// Loadable down-counter; last_o marks the final cycle of a SETUP or STROBE phase.
module cw305_usb_phase_timer #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    output logic             last_o
);

    logic [Width-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - Width'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign last_o = (count_q == '0);

endmodule

// File: rtl/cw305_usb_reg_master.sv
// Initiator for the CW305 USB parallel register bus: one command becomes a burst of byte cycles.
// Define USB_MASTER_RDREG_EN to add one strobe cycle (read data sampled on that extra cycle).
module cw305_usb_reg_master
    import cw305_usb_master_pkg::*;
#(
    parameter int unsigned pADDR_WIDTH    = 21,
    parameter int unsigned pBYTECNT_SIZE  = 7,
    parameter int unsigned pSETUP_CYCLES  = 1,
    parameter int unsigned pSTROBE_CYCLES = 2
) (
    input  logic                     usb_clk,
    input  logic                     rst,
    input  logic                     I_cmd_valid,
    output logic                     O_cmd_ready,
    input  logic                     I_cmd_write,
    input  logic [pADDR_WIDTH-1:0]   I_cmd_addr,
    input  logic [pBYTECNT_SIZE:0]   I_cmd_len,
    input  logic [7:0]               I_wr_data,
    input  logic                     I_wr_valid,
    output logic                     O_wr_ready,
    output logic [7:0]               O_rd_data,
    output logic                     O_rd_valid,
    output logic                     O_done,
    output logic [pADDR_WIDTH-1:0]   O_usb_addr,
    output logic [7:0]               O_usb_dout,
    output logic                     O_usb_drive,
    input  logic [7:0]               I_usb_din,
    output logic                     O_usb_ncs,
    output logic                     O_usb_nrd,
    output logic                     O_usb_nwe
);

    localparam logic [TimerWidth-1:0] SetupLoad  = phase_load(pSETUP_CYCLES);
    localparam logic [TimerWidth-1:0] StrobeLoad = phase_load(strobe_len(pSTROBE_CYCLES));
    localparam logic [pBYTECNT_SIZE:0]   LenOne  = {{pBYTECNT_SIZE{1'b0}}, 1'b1};
    localparam logic [pBYTECNT_SIZE-1:0] IdxOne  = {{(pBYTECNT_SIZE-1){1'b0}}, 1'b1};

    state_e                   state_q, state_d;
    logic [pADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [7:0]               dout_q, dout_d;
    logic [pBYTECNT_SIZE:0]   remain_q, remain_d;
    logic                     write_q, write_d;
    logic                     drive_q, drive_d;
    logic [7:0]               rd_data_q;
    logic                     rd_valid_q;
    logic                     wr_ready;
    logic                     timer_load;
    logic [TimerWidth-1:0]    timer_val;
    logic                     timer_last;
    logic                     rd_sample;

    cw305_usb_phase_timer #(
        .Width (TimerWidth)
    ) u_phase_timer (
        .clk_i      (usb_clk),
        .rst_i      (rst),
        .load_i     (timer_load),
        .load_val_i (timer_val),
        .last_o     (timer_last)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        dout_d     = dout_q;
        remain_d   = remain_q;
        write_d    = write_q;
        drive_d    = drive_q;
        wr_ready   = 1'b0;
        timer_load = 1'b0;
        timer_val  = SetupLoad;
        unique case (state_q)
            StIdle: begin
                if (I_cmd_valid) begin
                    addr_d   = I_cmd_addr;
                    remain_d = I_cmd_len;
                    write_d  = I_cmd_write;
                    if (I_cmd_len == '0) begin
                        state_d = StDone;
                    end else if (I_cmd_write) begin
                        state_d = StWdata;
                    end else begin
                        state_d    = StSetup;
                        timer_load = 1'b1;
                    end
                end
            end
            StWdata: begin
                if (I_wr_valid) begin
                    dout_d     = I_wr_data;
                    wr_ready   = 1'b1;
                    drive_d    = 1'b1;
                    state_d    = StSetup;
                    timer_load = 1'b1;
                end
            end
            StSetup: begin
                if (timer_last) begin
                    state_d    = StStrobe;
                    timer_load = 1'b1;
                    timer_val  = StrobeLoad;
                end
            end
            StStrobe: begin
                if (timer_last) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                remain_d = remain_q - LenOne;
                // Address is left alone on the last byte so drive can fall without an address change.
                if (remain_q == LenOne) begin
                    state_d = StDone;
                    drive_d = 1'b0;
                end else begin
                    addr_d = {addr_q[pADDR_WIDTH-1:pBYTECNT_SIZE],
                              addr_q[pBYTECNT_SIZE-1:0] + IdxOne};
                    if (write_q) begin
                        state_d = StWdata;
                    end else begin
                        state_d    = StSetup;
                        timer_load = 1'b1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign rd_sample = (state_q == StStrobe) && timer_last && !write_q;

    always_ff @(posedge usb_clk) begin
        if (rst) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            dout_q     <= '0;
            remain_q   <= '0;
            write_q    <= 1'b0;
            drive_q    <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            dout_q     <= dout_d;
            remain_q   <= remain_d;
            write_q    <= write_d;
            drive_q    <= drive_d;
            rd_valid_q <= rd_sample;
            if (rd_sample) begin
                rd_data_q <= I_usb_din;
            end
        end
    end

    assign O_cmd_ready = (state_q == StIdle);
    assign O_wr_ready  = wr_ready;
    assign O_rd_data   = rd_data_q;
    assign O_rd_valid  = rd_valid_q;
    assign O_done      = (state_q == StDone);
    assign O_usb_addr  = addr_q;
    assign O_usb_dout  = dout_q;
    assign O_usb_drive = drive_q;
    assign O_usb_ncs   = !((state_q == StWdata) || (state_q == StSetup) ||
                           (state_q == StStrobe) || (state_q == StHold));
    assign O_usb_nwe   = !((state_q == StStrobe) && write_q);
    assign O_usb_nrd   = !((state_q == StStrobe) && !write_q);

endmodule
